// File: rtl/lab8_soc_pio_arbiter_pkg.sv
// Shared encodings for the PIO arbiter: requester operation codes and sequencer states.
package lab8_soc_pio_pkg;

  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_RD  = 2'b01,
    OP_SET = 2'b10,
    OP_CLR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RMW_WR,
    S_DONE
  } state_e;

endpackage

// File: rtl/lab8_soc_pio_arbiter_if.sv
// Avalon-MM bus toward a single PIO s1 slave (zero-latency combinational readdata).
interface lab8_soc_pio_arbiter_if #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/lab8_soc_pio_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
module rr_pick #(
  parameter  int NREQ  = 4,
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] index,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // NOTE: every combinationally assigned signal gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = '0;
    index = '0;
    valid = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IDX_W'((int'(ptr) + i) % NREQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
    grant[index] = valid;
  end

endmodule

// File: rtl/lab8_soc_pio_arbiter.sv
// Round-robin sequencer sharing one PIO slave among NREQ requesters; supports write,
// read and atomic bit-set / bit-clear (read then write) with registered bus outputs.
module lab8_soc_pio_arbiter
  import lab8_soc_pio_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [ADDR_W*NREQ-1:0]   req_addr,
  input  logic [DATA_W*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]          ack,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  lab8_soc_pio_arbiter_if.master   bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [NREQ-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic              cs_q, cs_d, wn_q, wn_d;
  logic [DATA_W-1:0] wd_q, wd_d, rdata_d;
  logic [NREQ-1:0]   ack_d;
  logic              busy_d;

  logic [NREQ-1:0]   pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  op_e               pick_op;
  logic [DATA_W-1:0] pick_data, rmw_val;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .index (pick_idx),
    .valid (pick_valid)
  );

  assign pick_op   = op_e'(req_op[2*int'(pick_idx) +: 2]);
  assign pick_data = req_data[DATA_W*int'(pick_idx) +: DATA_W];
  // Modified value is formed straight from the slave's readdata during the read beat.
  assign rmw_val   = (op_q == OP_SET) ? (bus.readdata | mask_q) : (bus.readdata & ~mask_q);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sel_d     = sel_q;
    mask_d    = mask_q;
    ptr_d     = ptr_q;
    address_d = address_q;
    cs_d      = 1'b0;
    wn_d      = 1'b1;
    wd_d      = wd_q;
    ack_d     = '0;
    rdata_d   = rdata;
    busy_d    = busy;
    unique case (state_q)
      S_IDLE: if (pick_valid) begin
        op_d      = pick_op;
        sel_d     = pick_grant;
        mask_d    = pick_data;
        ptr_d     = IDX_W'((int'(pick_idx) + 1) % NREQ);
        address_d = req_addr[ADDR_W*int'(pick_idx) +: ADDR_W];
        cs_d      = 1'b1;
        wn_d      = (pick_op != OP_WR);
        if (pick_op == OP_WR) wd_d = pick_data;
        busy_d    = 1'b1;
        state_d   = S_ISSUE;
      end
      S_ISSUE: begin
        if (op_q == OP_WR) begin
          ack_d   = sel_q;
          state_d = S_DONE;
        end else begin
          rdata_d = bus.readdata;
          if (op_q == OP_RD) begin
            ack_d   = sel_q;
            state_d = S_DONE;
          end else begin
            cs_d    = 1'b1;
            wn_d    = 1'b0;
            wd_d    = rmw_val;
            state_d = S_RMW_WR;
          end
        end
      end
      S_RMW_WR: begin
        ack_d   = sel_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples the pre-edge values together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_WR;
      sel_q     <= '0;
      mask_q    <= '0;
      ptr_q     <= '0;
      address_q <= '0;
      cs_q      <= 1'b0;
      wn_q      <= 1'b1;
      wd_q      <= '0;
      ack       <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sel_q     <= sel_d;
      mask_q    <= mask_d;
      ptr_q     <= ptr_d;
      address_q <= address_d;
      cs_q      <= cs_d;
      wn_q      <= wn_d;
      wd_q      <= wd_d;
      ack       <= ack_d;
      rdata     <= rdata_d;
      busy      <= busy_d;
    end
  end

  assign bus.address    = address_q;
  assign bus.chipselect = cs_q;
  assign bus.write_n    = wn_q;
  assign bus.writedata  = wd_q;

endmodule

// File: tb/tb_lab8_soc_pio_arbiter.sv
// Bench for lab8_soc_pio_arbiter: PIO slave model, transaction-level reference timeline
// checked every cycle, plus directed scenarios with hand-computed expectations.
module tb_lab8_soc_pio_arbiter;
  import lab8_soc_pio_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [7:0]  req_op;
  logic [7:0]  req_addr;
  logic [127:0] req_data;
  logic [3:0]  ack;
  logic [31:0] rdata;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  lab8_soc_pio_arbiter_if #(.ADDR_W(2), .DATA_W(32)) bus ();

  lab8_soc_pio_arbiter #(.NREQ(4), .DATA_W(32), .ADDR_W(2)) dut (
    .clk      (clk),
    .reset_n  (rst_n),
    .req      (req),
    .req_op   (req_op),
    .req_addr (req_addr),
    .req_data (req_data),
    .ack      (ack),
    .rdata    (rdata),
    .busy     (busy),
    .bus      (bus.master)
  );

  always #5 clk = ~clk;

  // PIO slave: zero-latency read, write on the clock edge.
  logic [31:0] pio_mem [4] = '{default: 32'h0};
  assign bus.readdata = pio_mem[bus.address];
  always @(posedge clk)
    if (bus.chipselect && !bus.write_n) pio_mem[bus.address] <= bus.writedata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each granted op occupies a fixed run of per-cycle slots in a timeline.
  typedef struct {
    logic        cs;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] wd;
    logic [3:0]  ack;
    logic        busy;
    logic [31:0] rdata;
    bit          commit;
  } exp_t;

  exp_t        q[$];
  exp_t        cur;
  logic [31:0] mreg [4] = '{default: 32'h0};
  logic [31:0] m_rdata;
  int          mptr;

  function automatic exp_t idle_rec(input logic [31:0] rd);
    exp_t r;
    r.cs = 1'b0; r.wn = 1'b1; r.addr = 2'd0; r.wd = 32'h0;
    r.ack = 4'h0; r.busy = 1'b0; r.rdata = rd; r.commit = 1'b0;
    return r;
  endfunction

  initial begin
    cur     = idle_rec(32'h0);
    m_rdata = 32'h0;
    mptr    = 0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      cur     = idle_rec(32'h0);
      m_rdata = 32'h0;
      mptr    = 0;
    end else begin
      exp_t r, r2;
      int w;
      op_e op;
      logic [1:0] a;
      logic [31:0] d, old;
      if (cur.commit) mreg[cur.addr] = cur.wd;
      if (q.size() == 0 && req != 4'h0) begin
        w = -1;
        for (int k = 0; k < 4; k++)
          if (w < 0 && req[(mptr + k) % 4]) w = (mptr + k) % 4;
        op   = op_e'(req_op[2*w +: 2]);
        a    = req_addr[2*w +: 2];
        d    = req_data[32*w +: 32];
        mptr = (w + 1) % 4;
        r = idle_rec(m_rdata);
        r.cs = 1'b1; r.addr = a; r.busy = 1'b1;
        if (op == OP_WR) begin
          r.wn = 1'b0; r.wd = d; r.commit = 1'b1;
          q.push_back(r);
        end else begin
          q.push_back(r);
          old = mreg[a];
          m_rdata = old;
          if (op != OP_RD) begin
            r2 = idle_rec(old);
            r2.cs = 1'b1; r2.wn = 1'b0; r2.addr = a; r2.busy = 1'b1; r2.commit = 1'b1;
            r2.wd = (op == OP_SET) ? (old | d) : (old & ~d);
            q.push_back(r2);
          end
        end
        r2 = idle_rec(m_rdata);
        r2.busy = 1'b1;
        r2.ack  = 4'b0001 << w;
        q.push_back(r2);
        q.push_back(idle_rec(m_rdata));
      end
      cur = (q.size() > 0) ? q.pop_front() : idle_rec(m_rdata);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("ack", 32'(ack), 32'(cur.ack));
      check("busy", 32'(busy), 32'(cur.busy));
      check("chipselect", 32'(bus.chipselect), 32'(cur.cs));
      check("write_n", 32'(bus.write_n), 32'(cur.wn));
      check("rdata", rdata, cur.rdata);
      if (cur.cs) check("address", 32'(bus.address), 32'(cur.addr));
      if (cur.cs && !cur.wn) check("writedata", bus.writedata, cur.wd);
    end
  end

  // Single request: returns negedge count to ack, first-bus-beat snapshot, rdata at ack.
  task automatic do_op(input int i, input op_e op, input logic [1:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] wd1, output logic cs1, output logic wn1,
                       output logic [31:0] rd);
    bit got = 1'b0;
    lat = 0; wd1 = 32'h0; cs1 = 1'b0; wn1 = 1'b1; rd = 32'h0;
    req_op[2*i +: 2]   = op;
    req_addr[2*i +: 2] = a;
    req_data[32*i +: 32] = d;
    req[i] = 1'b1;
    for (int n = 1; n <= 20 && !got; n++) begin
      @(negedge clk);
      if (n == 2) begin cs1 = bus.chipselect; wn1 = bus.write_n; wd1 = bus.writedata; end
      if (ack[i]) begin got = 1'b1; lat = n; rd = rdata; end
    end
    check("op_ack_seen", 32'(got), 32'd1);
    @(posedge clk); #1;
    req[i] = 1'b0;
  endtask

  int acks_idx [8];
  int acks_cyc [8];

  task automatic run_multi(input logic [3:0] mask, input int nacks);
    int cnt = 0;
    req = mask;
    for (int n = 1; n <= 60 && cnt < nacks; n++) begin
      @(negedge clk);
      if (ack != 4'h0) begin
        for (int j = 0; j < 4; j++) if (ack[j]) acks_idx[cnt] = j;
        acks_cyc[cnt] = n;
        cnt++;
      end
    end
    check("multi_ack_count", 32'(cnt), 32'(nacks));
    @(posedge clk); #1;
    req = 4'h0;
  endtask

  initial begin
    int lat, cs_cnt;
    logic [31:0] wd1, rd;
    logic cs1, wn1;
    rst_n = 1'b0; req = '0; req_op = '0; req_addr = '0; req_data = '0;
    repeat (2) @(negedge clk);
    check("rst_cs", 32'(bus.chipselect), 32'd0);
    check("rst_write_n", 32'(bus.write_n), 32'd1);
    check("rst_address", 32'(bus.address), 32'd0);
    check("rst_writedata", bus.writedata, 32'h0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Plain write from requester 0.
    do_op(0, OP_WR, 2'd0, 32'h5A, lat, wd1, cs1, wn1, rd);
    check("wr_latency", 32'(lat), 32'd3);
    check("wr_beat_cs", 32'(cs1), 32'd1);
    check("wr_beat_wn", 32'(wn1), 32'd0);
    check("wr_beat_wd", wd1, 32'h5A);
    check("wr_pio0", pio_mem[0], 32'h5A);

    // Bit-set on a register holding 0x0F.
    do_op(3, OP_WR, 2'd1, 32'h0F, lat, wd1, cs1, wn1, rd);
    do_op(2, OP_SET, 2'd1, 32'h30, lat, wd1, cs1, wn1, rd);
    check("set_latency", 32'(lat), 32'd4);
    check("set_rdata", rd, 32'h0F);
    check("set_pio1", pio_mem[1], 32'h3F);

    // Bit-clear on 0xFF, then read back.
    do_op(1, OP_WR, 2'd2, 32'hFF, lat, wd1, cs1, wn1, rd);
    do_op(1, OP_CLR, 2'd2, 32'h81, lat, wd1, cs1, wn1, rd);
    check("clr_rdata", rd, 32'hFF);
    check("clr_pio2", pio_mem[2], 32'h7E);
    do_op(1, OP_RD, 2'd2, 32'h0, lat, wd1, cs1, wn1, rd);
    check("rd_latency", 32'(lat), 32'd3);
    check("rd_rdata", rd, 32'h7E);

    // Move pointer to 3, then requesters 3 and 0 together: 3 first, 0 after wrap.
    do_op(2, OP_WR, 2'd0, 32'h11, lat, wd1, cs1, wn1, rd);
    req_op = '0;
    req_addr[6 +: 2] = 2'd3; req_data[96 +: 32] = 32'h33;
    req_addr[0 +: 2] = 2'd0; req_data[0 +: 32]  = 32'h44;
    run_multi(4'b1001, 2);
    check("wrap_first", 32'(acks_idx[0]), 32'd3);
    check("wrap_second", 32'(acks_idx[1]), 32'd0);
    cs_cnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (bus.chipselect) cs_cnt++;
    end
    check("idle_no_bus", 32'(cs_cnt), 32'd0);

    // Reset during the write half of a bit-set: no partial write reaches the PIO.
    do_op(0, OP_WR, 2'd3, 32'h01, lat, wd1, cs1, wn1, rd);
    req_op[0 +: 2] = OP_SET; req_addr[0 +: 2] = 2'd3; req_data[0 +: 32] = 32'hF0;
    req[0] = 1'b1;
    repeat (3) @(negedge clk);
    check("rmw_beat_cs", 32'(bus.chipselect), 32'd1);
    check("rmw_beat_wn", 32'(bus.write_n), 32'd0);
    check("rmw_beat_wd", bus.writedata, 32'hF1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_cs", 32'(bus.chipselect), 32'd0);
    check("abort_write_n", 32'(bus.write_n), 32'd1);
    check("abort_ack", 32'(ack), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    req[0] = 1'b0;
    @(posedge clk); #1;
    check("abort_pio3", pio_mem[3], 32'h01);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All four held: pointer restarted at 0, strict rotation, 3-cycle spacing.
    req_op = '0;
    for (int i = 0; i < 4; i++) begin
      req_addr[2*i +: 2]   = 2'(i);
      req_data[32*i +: 32] = 32'hA0 + 32'(i);
    end
    run_multi(4'b1111, 5);
    check("rot_first_latency", 32'(acks_cyc[0]), 32'd3);
    for (int k = 0; k < 5; k++) check("rot_order", 32'(acks_idx[k]), 32'(k % 4));
    for (int k = 1; k < 5; k++) check("rot_spacing", 32'(acks_cyc[k] - acks_cyc[k-1]), 32'd3);
    repeat (4) @(negedge clk);

    for (int a = 0; a < 4; a++) check("pio_vs_model", pio_mem[a], mreg[a]);
    check("rot_pio3", pio_mem[3], 32'hA3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
